dec_md_seq: RTL and testbench
=============================

DEC_MD_SEQ -- requirements
Module: dec_md_seq

Interface
REQ-001 Parameter MUL_CYCLES, default 2, multiplier latency in cycles (legal range 1..63).
REQ-002 Parameter DIV_CYCLES, default 34, divider latency in cycles (legal range 1..63).
REQ-003 Parameter CNT_W, default 6, width of the latency counter; it SHALL hold max(MUL_CYCLES, DIV_CYCLES)-1.
REQ-004 clk  in  1  sole clock; all state updates on the rising edge.
REQ-005 resetn  in  1  reset; asynchronous, active-low.
REQ-006 inst_valid  in  1  decode-stage instruction present.
REQ-007 op/rs/rt/rd/funct  in  6/5/5/5/6  instruction fields.
REQ-008 stall_in  in  1  downstream (EX) stall; holds the output register.
REQ-009 flush  in  1  squashes the instruction currently in decode.
REQ-010 out_valid  out  1  registered control bundle is valid.
REQ-011 regwrite, regdst, alusrc, branch, bal, jal, jr, jump, memWrite, memToReg  out  1 each  registered datapath controls.
REQ-012 hiloToReg, hilosrc, regToHilo_hi, regToHilo_lo, isSign  out  1 each  registered HI/LO controls.
REQ-013 ri_excp  out  1  registered reserved-instruction flag.
REQ-014 stall_out  out  1  combinational stall request to fetch/decode.
REQ-015 md_start  out  1  one-cycle pulse that launches a multiply/divide.
REQ-016 md_is_div, md_sign  out  1 each  operation type and signedness, held for the whole operation.
REQ-017 md_busy  out  1  multiply/divide in flight.
REQ-018 hilo_we  out  1  one-cycle pulse; the mul/div result is written to HI/LO.

Function
REQ-019 Decoding SHALL follow the MIPS32 subset: R-type ALU/shift ops, JR, JALR, MFHI/MFLO/MTHI/MTLO, MULT(U), DIV(U); ADDI(U), SLTI(U), ANDI, ORI, XORI, LUI; BEQ/BNE/BGTZ/BLEZ; REGIMM BGEZ/BLTZ/BGEZAL/BLTZAL; J, JAL; LB/LBU/LH/LHU/LW; SB/SH/SW.
REQ-020 BNE SHALL NOT assert regwrite.
REQ-021 Any other op/funct/rt encoding SHALL set ri_excp=1 with all write enables 0.
REQ-022 The FSM SHALL have the states IDLE, MUL, DIV.
REQ-023 An instruction is accepted when inst_valid=1, flush=0, stall_out=0 and stall_in=0.
REQ-024 On acceptance, the decoded bundle SHALL be registered and out_valid=1 in the next cycle (latency 1).
REQ-025 An accepted MULT(U) in IDLE SHALL pulse md_start, go to MUL, and load counter=MUL_CYCLES-1.
REQ-026 An accepted DIV(U) in IDLE SHALL pulse md_start, go to DIV, and load counter=DIV_CYCLES-1.
REQ-027 md_sign=1 SHALL be set for MULT/DIV; md_is_div=1 SHALL be set for DIV/DIVU.
REQ-028 In MUL/DIV the counter SHALL decrement each cycle; md_busy=1.
REQ-029 In the cycle with counter==0, hilo_we SHALL pulse and the next state SHALL be IDLE.
REQ-030 For N cycles of latency, hilo_we SHALL fire N cycles after md_start.
REQ-031 stall_out SHALL be 1 when inst_valid=1 and the decode instruction is MFHI/MFLO/MTHI/MTLO/MULT(U)/DIV(U) while md_busy=1, including the hilo_we cycle.
REQ-032 The HI/LO-independent stall release SHALL occur in the cycle after hilo_we.
REQ-033 stall_out SHALL be 1 whenever stall_in=1.
REQ-034 If stall_in=1, all registered outputs SHALL hold their values.
REQ-035 If stall_in=0, flush=0 and the instruction is not accepted, out_valid SHALL be 0 (bubble) and all controls SHALL be zero.
REQ-036 flush=1 SHALL bubble the decode instruction and SHALL NOT start a mul/div.
REQ-037 An in-flight mul/div SHALL complete regardless of flush or stall_in.
REQ-038 flush and stall_in asserted together: flush wins for acceptance; the output register still holds.

Reset
REQ-039 resetn=0 SHALL immediately set state=IDLE, counter=0, out_valid=0, all registered controls=0, md_busy=0, md_start=0, hilo_we=0.
REQ-040 Reset asserted mid-operation SHALL abort the mul/div with no hilo_we.
REQ-041 The first acceptance is possible on the first clock edge after resetn rises.

Verification
REQ-042 ADDIU (op 001001) accepted -> next cycle out_valid=1, regwrite=1, alusrc=1, regdst=0, ri_excp=0.
REQ-043 DIV at t0 with default parameters -> md_start at t0, md_busy t0+1..t0+34, hilo_we at t0+34; MFLO presented at t0+2 -> stall_out=1 through t0+34, accepted at t0+35.
REQ-044 MULTU with MUL_CYCLES=1 -> hilo_we 1 cycle after md_start; back-to-back MULTU stalls exactly 1 cycle.
REQ-045 op=111111 -> ri_excp=1, regwrite=0, memWrite=0, no md_start.
REQ-046 DIV in flight, flush on a MULT in decode -> no second md_start, first hilo_we still at t0+34.
REQ-047 resetn low at t0+10 of a DIV -> md_busy=0 immediately, no hilo_we, then ADDU accepted normally.

Source files
------------

// File: rtl/dec_md_seq.sv
// rtl/dec_md_seq.sv - MIPS32-subset decode stage with registered control bundle
// and a fixed-latency multiply/divide sequencer that drives HI/LO interlocks.
module dec_md_seq #(
  parameter int MUL_CYCLES = 2,
  parameter int DIV_CYCLES = 34,
  parameter int CNT_W      = 6
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       inst_valid,
  input  logic [5:0] op,
  input  logic [4:0] rs,
  input  logic [4:0] rt,
  input  logic [4:0] rd,
  input  logic [5:0] funct,
  input  logic       stall_in,
  input  logic       flush,
  output logic       out_valid,
  output logic       regwrite,
  output logic       regdst,
  output logic       alusrc,
  output logic       branch,
  output logic       bal,
  output logic       jal,
  output logic       jr,
  output logic       jump,
  output logic       memWrite,
  output logic       memToReg,
  output logic       hiloToReg,
  output logic       hilosrc,
  output logic       regToHilo_hi,
  output logic       regToHilo_lo,
  output logic       isSign,
  output logic       ri_excp,
  output logic       stall_out,
  output logic       md_start,
  output logic       md_is_div,
  output logic       md_sign,
  output logic       md_busy,
  output logic       hilo_we
);

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

  typedef struct packed {
    logic regwrite;
    logic regdst;
    logic alusrc;
    logic branch;
    logic bal;
    logic jal;
    logic jr;
    logic jump;
    logic mem_write;
    logic mem_to_reg;
    logic hilo_to_reg;
    logic hilosrc;
    logic reg_to_hilo_hi;
    logic reg_to_hilo_lo;
    logic is_sign;
    logic ri_excp;
  } ctrl_t;

  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

  ctrl_t            dec;
  ctrl_t            ctrl_q;
  logic             dec_mul;
  logic             dec_div;
  logic             dec_sign;
  logic             dec_hilo;
  logic             accept;
  state_t           state;
  state_t           state_n;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_n;
  logic             md_is_div_q;
  logic             md_sign_q;
  logic             unused_fields;

  // Register addresses are routed by the datapath; decode only needs opcodes.
  assign unused_fields = ^{rs, rd};

  always_comb begin
    dec      = '0;
    dec_mul  = 1'b0;
    dec_div  = 1'b0;
    dec_sign = 1'b0;
    dec_hilo = 1'b0;
    case (op)
      6'b000000: begin
        case (funct)
          6'b100000, 6'b100001, 6'b100010, 6'b100011,
          6'b100100, 6'b100101, 6'b100110, 6'b100111,
          6'b101010, 6'b101011,
          6'b000000, 6'b000010, 6'b000011,
          6'b000100, 6'b000110, 6'b000111: begin
            dec.regwrite = 1'b1;
            dec.regdst   = 1'b1;
          end
          6'b001000: dec.jr = 1'b1;
          6'b001001: begin
            dec.jr       = 1'b1;
            dec.regwrite = 1'b1;
            dec.regdst   = 1'b1;
          end
          6'b010000, 6'b010010: begin
            dec.regwrite    = 1'b1;
            dec.regdst      = 1'b1;
            dec.hilo_to_reg = 1'b1;
            dec.hilosrc     = ~funct[1];
            dec_hilo        = 1'b1;
          end
          6'b010001: begin
            dec.reg_to_hilo_hi = 1'b1;
            dec_hilo           = 1'b1;
          end
          6'b010011: begin
            dec.reg_to_hilo_lo = 1'b1;
            dec_hilo           = 1'b1;
          end
          6'b011000, 6'b011001, 6'b011010, 6'b011011: begin
            dec_div  = funct[1];
            dec_mul  = ~funct[1];
            dec_sign = ~funct[0];
            dec_hilo = 1'b1;
          end
          default: dec.ri_excp = 1'b1;
        endcase
      end
      6'b000001: begin
        case (rt)
          5'b00000, 5'b00001: dec.branch = 1'b1;
          5'b10000, 5'b10001: begin
            dec.branch   = 1'b1;
            dec.bal      = 1'b1;
            dec.regwrite = 1'b1;
          end
          default: dec.ri_excp = 1'b1;
        endcase
      end
      6'b000010: dec.jump = 1'b1;
      6'b000011: begin
        dec.jump     = 1'b1;
        dec.jal      = 1'b1;
        dec.regwrite = 1'b1;
      end
      6'b000100, 6'b000101, 6'b000110, 6'b000111: dec.branch = 1'b1;
      6'b001000, 6'b001001, 6'b001010, 6'b001011: begin
        dec.regwrite = 1'b1;
        dec.alusrc   = 1'b1;
        dec.is_sign  = 1'b1;
      end
      6'b001100, 6'b001101, 6'b001110, 6'b001111: begin
        dec.regwrite = 1'b1;
        dec.alusrc   = 1'b1;
      end
      6'b100000, 6'b100001, 6'b100011, 6'b100100, 6'b100101: begin
        dec.regwrite   = 1'b1;
        dec.alusrc     = 1'b1;
        dec.mem_to_reg = 1'b1;
        dec.is_sign    = 1'b1;
      end
      6'b101000, 6'b101001, 6'b101011: begin
        dec.mem_write = 1'b1;
        dec.alusrc    = 1'b1;
        dec.is_sign   = 1'b1;
      end
      default: dec.ri_excp = 1'b1;
    endcase
  end

  // HI/LO users wait until the cycle after hilo_we, when the FSM is back in IDLE.
  assign md_busy   = (state != IDLE);
  assign stall_out = stall_in | (inst_valid & dec_hilo & md_busy);
  assign accept    = resetn & inst_valid & ~flush & ~stall_out;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      out_valid <= 1'b0;
      ctrl_q    <= '0;
    end else if (!stall_in) begin
      out_valid <= accept;
      ctrl_q    <= accept ? dec : '0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= IDLE;
      cnt         <= '0;
      md_is_div_q <= 1'b0;
      md_sign_q   <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (md_start) begin
        md_is_div_q <= dec_div;
        md_sign_q   <= dec_sign;
      end
    end
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    md_start = 1'b0;
    hilo_we  = 1'b0;
    case (state)
      IDLE: begin
        if (accept && (dec_mul || dec_div)) begin
          md_start = 1'b1;
          state_n  = dec_div ? DIV : MUL;
          cnt_n    = dec_div ? DIV_LOAD : MUL_LOAD;
        end
      end
      MUL, DIV: begin
        if (cnt == '0) begin
          hilo_we = 1'b1;
          state_n = IDLE;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Type/sign are valid in the md_start cycle and held until the next launch.
  assign md_is_div = md_start ? dec_div  : md_is_div_q;
  assign md_sign   = md_start ? dec_sign : md_sign_q;

  assign regwrite     = ctrl_q.regwrite;
  assign regdst       = ctrl_q.regdst;
  assign alusrc       = ctrl_q.alusrc;
  assign branch       = ctrl_q.branch;
  assign bal          = ctrl_q.bal;
  assign jal          = ctrl_q.jal;
  assign jr           = ctrl_q.jr;
  assign jump         = ctrl_q.jump;
  assign memWrite     = ctrl_q.mem_write;
  assign memToReg     = ctrl_q.mem_to_reg;
  assign hiloToReg    = ctrl_q.hilo_to_reg;
  assign hilosrc      = ctrl_q.hilosrc;
  assign regToHilo_hi = ctrl_q.reg_to_hilo_hi;
  assign regToHilo_lo = ctrl_q.reg_to_hilo_lo;
  assign isSign       = ctrl_q.is_sign;
  assign ri_excp      = ctrl_q.ri_excp;

endmodule

// File: tb/tb_dec_md_seq.sv
// tb/tb_dec_md_seq.sv - directed bench for dec_md_seq (MUL_CYCLES=1, default divider).
module tb_dec_md_seq;

  logic       clk = 1'b0;
  logic       resetn;
  logic       inst_valid;
  logic [5:0] op;
  logic [4:0] rs;
  logic [4:0] rt;
  logic [4:0] rd;
  logic [5:0] funct;
  logic       stall_in;
  logic       flush;
  logic       out_valid, regwrite, regdst, alusrc, branch, bal, jal, jr, jump;
  logic       memWrite, memToReg, hiloToReg, hilosrc, regToHilo_hi, regToHilo_lo;
  logic       isSign, ri_excp, stall_out, md_start, md_is_div, md_sign, md_busy, hilo_we;

  int n_cmp = 0;
  int n_err = 0;
  int n_seen;

  always #5 clk = ~clk;

  dec_md_seq #(.MUL_CYCLES(1)) dut (
    .clk(clk), .resetn(resetn), .inst_valid(inst_valid), .op(op), .rs(rs), .rt(rt),
    .rd(rd), .funct(funct), .stall_in(stall_in), .flush(flush), .out_valid(out_valid),
    .regwrite(regwrite), .regdst(regdst), .alusrc(alusrc), .branch(branch), .bal(bal),
    .jal(jal), .jr(jr), .jump(jump), .memWrite(memWrite), .memToReg(memToReg),
    .hiloToReg(hiloToReg), .hilosrc(hilosrc), .regToHilo_hi(regToHilo_hi),
    .regToHilo_lo(regToHilo_lo), .isSign(isSign), .ri_excp(ri_excp),
    .stall_out(stall_out), .md_start(md_start), .md_is_div(md_is_div),
    .md_sign(md_sign), .md_busy(md_busy), .hilo_we(hilo_we)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [5:0] o, input logic [5:0] f, input logic [4:0] t);
    inst_valid = v;
    op         = o;
    funct      = f;
    rt         = t;
  endtask

  function automatic logic [14:0] bundle();
    return {regwrite, regdst, alusrc, branch, bal, jal, jr, jump, memWrite, memToReg,
            hiloToReg, hilosrc, regToHilo_hi, regToHilo_lo, ri_excp};
  endfunction

  // Expected bundle order: rw rdst asrc br bal jal jr jmp mw m2r h2r hsrc rthi rtlo ri
  task automatic dec_vec(input string tag, input logic [5:0] o, input logic [5:0] f,
                         input logic [4:0] t, input logic [14:0] exp);
    drive(1'b1, o, f, t);
    tick();
    check({tag, "_valid"}, out_valid, 1'b1);
    check(tag, bundle(), exp);
  endtask

  initial begin
    resetn = 1'b0; stall_in = 1'b0; flush = 1'b0; rs = 5'd3; rd = 5'd7;
    drive(1'b0, 6'd0, 6'd0, 5'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    drive(1'b1, 6'b000000, 6'b011010, 5'd0);
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_md_busy", md_busy, 1'b0);
    check("rst_hilo_we", hilo_we, 1'b0);
    check("rst_md_start", md_start, 1'b0);
    check("rst_bundle", bundle(), 15'd0);

    // first edge after reset release accepts
    @(posedge clk); #1;
    resetn = 1'b1;
    dec_vec("addiu", 6'b001001, 6'd0, 5'd0, 15'b1_0_1_0_0_0_0_0_0_0_0_0_0_0_0);
    check("addiu_issign", isSign, 1'b1);
    drive(1'b0, 6'b001001, 6'd0, 5'd0);
    tick();
    check("bubble_valid", out_valid, 1'b0);
    check("bubble_bundle", bundle(), 15'd0);

    dec_vec("addu",   6'b000000, 6'b100001, 5'd0,     15'b1_1_0_0_0_0_0_0_0_0_0_0_0_0_0);
    dec_vec("bne",    6'b000101, 6'd0,      5'd0,     15'b0_0_0_1_0_0_0_0_0_0_0_0_0_0_0);
    dec_vec("lw",     6'b100011, 6'd0,      5'd0,     15'b1_0_1_0_0_0_0_0_0_1_0_0_0_0_0);
    dec_vec("jal",    6'b000011, 6'd0,      5'd0,     15'b1_0_0_0_0_1_0_1_0_0_0_0_0_0_0);
    dec_vec("bgezal", 6'b000001, 6'd0,      5'b10001, 15'b1_0_0_1_1_0_0_0_0_0_0_0_0_0_0);
    dec_vec("jr",     6'b000000, 6'b001000, 5'd0,     15'b0_0_0_0_0_0_1_0_0_0_0_0_0_0_0);
    dec_vec("mfhi",   6'b000000, 6'b010000, 5'd0,     15'b1_1_0_0_0_0_0_0_0_0_1_1_0_0_0);
    dec_vec("mtlo",   6'b000000, 6'b010011, 5'd0,     15'b0_0_0_0_0_0_0_0_0_0_0_0_0_1_0);
    dec_vec("regimm_bad", 6'b000001, 6'd0,  5'b00011, 15'b0_0_0_0_0_0_0_0_0_0_0_0_0_0_1);
    dec_vec("funct_bad",  6'b000000, 6'b000001, 5'd0, 15'b0_0_0_0_0_0_0_0_0_0_0_0_0_0_1);
    drive(1'b1, 6'b111111, 6'd0, 5'd0);
    #1;
    check("op3f_md_start", md_start, 1'b0);
    dec_vec("op3f",   6'b111111, 6'd0,      5'd0,     15'b0_0_0_0_0_0_0_0_0_0_0_0_0_0_1);
    dec_vec("sw",     6'b101011, 6'd0,      5'd0,     15'b0_0_1_0_0_0_0_0_1_0_0_0_0_0_0);

    // stall_in holds the register; flush+stall still holds; flush alone bubbles
    drive(1'b1, 6'b001001, 6'd0, 5'd0);
    stall_in = 1'b1;
    #1;
    check("stallin_stall_out", stall_out, 1'b1);
    tick();
    check("hold_valid", out_valid, 1'b1);
    check("hold_bundle", bundle(), 15'b0_0_1_0_0_0_0_0_1_0_0_0_0_0_0);
    flush = 1'b1;
    tick();
    check("hold_fl_bundle", bundle(), 15'b0_0_1_0_0_0_0_0_1_0_0_0_0_0_0);
    stall_in = 1'b0;
    tick();
    check("flush_valid", out_valid, 1'b0);
    check("flush_bundle", bundle(), 15'd0);
    flush = 1'b0;
    tick();
    check("after_flush_rw", regwrite, 1'b1);

    // DIV at t0, flushed MULT at t0+1, MFLO from t0+2
    drive(1'b1, 6'b000000, 6'b011010, 5'd0);
    #1;
    check("div_md_start", md_start, 1'b1);
    check("div_is_div", md_is_div, 1'b1);
    check("div_sign", md_sign, 1'b1);
    check("div_stall_out", stall_out, 1'b0);
    tick();
    check("div_busy1", md_busy, 1'b1);
    check("div_valid1", out_valid, 1'b1);
    check("div_rw", regwrite, 1'b0);
    drive(1'b1, 6'b000000, 6'b011000, 5'd0);
    flush = 1'b1;
    #1;
    check("flush_mult_start", md_start, 1'b0);
    check("t1_hilo_we", hilo_we, 1'b0);
    tick();
    flush = 1'b0;
    drive(1'b1, 6'b000000, 6'b010010, 5'd0);
    for (int k = 2; k <= 34; k++) begin
      #1;
      check($sformatf("div_stall_t%0d", k), stall_out, 1'b1);
      check($sformatf("div_hilo_we_t%0d", k), hilo_we, (k == 34));
      check($sformatf("div_busy_t%0d", k), md_busy, 1'b1);
      check($sformatf("div_start_t%0d", k), md_start, 1'b0);
      tick();
      check($sformatf("div_bubble_t%0d", k), out_valid, 1'b0);
    end
    #1;
    check("t35_stall_out", stall_out, 1'b0);
    check("t35_busy", md_busy, 1'b0);
    check("t35_hilo_we", hilo_we, 1'b0);
    check("t35_md_is_div", md_is_div, 1'b1);
    tick();
    check("mflo_valid", out_valid, 1'b1);
    check("mflo_bundle", bundle(), 15'b1_1_0_0_0_0_0_0_0_0_1_0_0_0_0);

    // back-to-back MULTU with one-cycle multiplier
    drive(1'b1, 6'b000000, 6'b011001, 5'd0);
    #1;
    check("mu_start0", md_start, 1'b1);
    check("mu_is_div", md_is_div, 1'b0);
    check("mu_sign", md_sign, 1'b0);
    tick();
    #1;
    check("mu_hilo_we1", hilo_we, 1'b1);
    check("mu_busy1", md_busy, 1'b1);
    check("mu_stall1", stall_out, 1'b1);
    check("mu_start1", md_start, 1'b0);
    tick();
    check("mu_start2", md_start, 1'b1);
    check("mu_stall2", stall_out, 1'b0);
    check("mu_hilo_we2", hilo_we, 1'b0);
    tick();
    drive(1'b0, 6'd0, 6'd0, 5'd0);
    #1;
    check("mu_hilo_we3", hilo_we, 1'b1);
    tick();
    check("mu_busy4", md_busy, 1'b0);

    // reset at t0+10 of a DIV aborts it
    drive(1'b1, 6'b000000, 6'b011010, 5'd0);
    tick();
    drive(1'b0, 6'd0, 6'd0, 5'd0);
    repeat (9) tick();
    check("pre_rst_busy", md_busy, 1'b1);
    #2;
    resetn = 1'b0;
    #1;
    check("mid_rst_busy", md_busy, 1'b0);
    check("mid_rst_hilo_we", hilo_we, 1'b0);
    check("mid_rst_valid", out_valid, 1'b0);
    tick();
    resetn = 1'b1;
    drive(1'b1, 6'b000000, 6'b100001, 5'd0);
    tick();
    check("post_rst_valid", out_valid, 1'b1);
    check("post_rst_addu", bundle(), 15'b1_1_0_0_0_0_0_0_0_0_0_0_0_0_0);
    drive(1'b0, 6'd0, 6'd0, 5'd0);
    n_seen = 0;
    for (int k = 0; k < 40; k++) begin
      #1;
      if (hilo_we || md_busy) n_seen++;
      tick();
    end
    check("post_rst_no_hilo", n_seen, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
